// File: rtl/multi_timestamp_core.sv
// Multi-channel edge timestamper: per-channel capture slots, round-robin
// serialiser into 3-word tagged events, FWFT output FIFO and byte register bus.
module multi_timestamp_core #(
    parameter int         ABUSWIDTH  = 16,
    parameter logic [3:0] IDENTIFIER = 4'b0001,
    parameter int         CHANNELS   = 4,
    parameter int         TS_WIDTH   = 64,
    parameter int         DEPTH      = 1024
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [CHANNELS-1:0]  DI,
    input  logic                 EXT_ENABLE,
    input  logic [63:0]          EXT_TIMESTAMP,
    output logic [TS_WIDTH-1:0]  TIMESTAMP_OUT,
    input  logic                 FIFO_READ,
    output logic                 FIFO_EMPTY,
    output logic [31:0]          FIFO_DATA,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, W1, W2, W3} state_t;

    logic                rst;
    logic                conf_en, conf_ext_ts, conf_ext_en;
    logic [CHANNELS-1:0] rise_mask, fall_mask;
    logic [15:0]         rise16, fall16;
    logic [TS_WIDTH-1:0] counter;
    logic [CHANNELS-1:0] s0, s1, s2, rise, fall, hit, accept, lost;
    logic [CHANNELS-1:0] pending, free, edge_slot;
    logic [63:0]         ts_slot [CHANNELS];
    logic [63:0]         cap_ts, sel_ts;
    logic                sel_edge, en;
    logic [7:0]          lost_cnt, rd_mux;
    logic [8:0]          lost_sum;
    logic [4:0]          n_lost, pend_cnt;
    state_t              state;
    logic [3:0]          grant, pick;
    logic                found;
    int                  tgt;
    logic [31:0]         mem [DEPTH];
    logic [AW:0]         wp, rp;
    logic                full, wr, rd;
    logic [31:0]         wr_data;

    assign rst    = BUS_RST | (BUS_WR & (BUS_ADD == '0));
    assign rise16 = 16'(rise_mask);
    assign fall16 = 16'(fall_mask);

    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            conf_en     <= 1'b0;
            conf_ext_ts <= 1'b0;
            conf_ext_en <= 1'b1;
            rise_mask   <= '1;
            fall_mask   <= '0;
        end else if (BUS_WR) begin
            case (BUS_ADD)
                ABUSWIDTH'(1): {conf_ext_en, conf_ext_ts, conf_en} <= BUS_DATA_IN[2:0];
                ABUSWIDTH'(2): rise_mask <= CHANNELS'({rise16[15:8], BUS_DATA_IN});
                ABUSWIDTH'(3): rise_mask <= CHANNELS'({BUS_DATA_IN, rise16[7:0]});
                ABUSWIDTH'(4): fall_mask <= CHANNELS'({fall16[15:8], BUS_DATA_IN});
                ABUSWIDTH'(5): fall_mask <= CHANNELS'({BUS_DATA_IN, fall16[7:0]});
                default: ;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst) counter <= '0;
        else     counter <= counter + TS_WIDTH'(1);
    end

    assign TIMESTAMP_OUT = counter;

    // Synchroniser is left out of reset so a level held across reset is not seen as an edge
    always_ff @(posedge BUS_CLK) begin
        s0 <= DI;
        s1 <= s0;
        s2 <= s1;
    end

    assign rise   = s1 & ~s2;
    assign fall   = ~s1 & s2;
    assign en     = conf_en | (EXT_ENABLE & conf_ext_en);
    assign hit    = en ? ((rise & rise_mask) | (fall & fall_mask)) : '0;
    assign accept = hit & (~pending | free);
    assign lost   = hit & ~accept;
    assign cap_ts = conf_ext_ts ? EXT_TIMESTAMP : 64'(counter);

    always_comb begin
        free     = '0;
        sel_ts   = '0;
        sel_edge = 1'b0;
        n_lost   = '0;
        pend_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            free[c]  = (state == W3) && !full && (grant == 4'(c));
            n_lost   = n_lost + 5'(lost[c]);
            pend_cnt = pend_cnt + 5'(pending[c]);
            if (grant == 4'(c)) begin
                sel_ts   = ts_slot[c];
                sel_edge = edge_slot[c];
            end
        end
    end

    assign lost_sum = {1'b0, lost_cnt} + 9'(n_lost);

    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            pending  <= '0;
            lost_cnt <= '0;
        end else begin
            pending  <= (pending & ~free) | accept;
            lost_cnt <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
        end
    end

    always_ff @(posedge BUS_CLK) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept[c]) begin
                ts_slot[c]   <= cap_ts;
                edge_slot[c] <= rise[c];
            end
        end
    end

    // Round-robin search starting just after the previous grant
    always_comb begin
        found = 1'b0;
        pick  = '0;
        tgt   = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            tgt = int'(grant) + i;
            if (tgt >= CHANNELS) tgt = tgt - CHANNELS;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!found && pending[c] && (tgt == c)) begin
                    found = 1'b1;
                    pick  = 4'(c);
                end
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            state <= IDLE;
            grant <= 4'(CHANNELS - 1);
        end else begin
            unique case (state)
                IDLE: if (found) begin
                    grant <= pick;
                    state <= W1;
                end
                W1: if (!full) state <= W2;
                W2: if (!full) state <= W3;
                W3: if (!full) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_data = '0;
        unique case (state)
            W1: wr_data = {IDENTIFIER, 4'h1, sel_ts[23:0]};
            W2: wr_data = {IDENTIFIER, 4'h2, sel_ts[47:24]};
            W3: wr_data = {IDENTIFIER, 4'h3, grant, sel_edge, 3'b000, sel_ts[63:48]};
            default: wr_data = '0;
        endcase
    end

    assign full       = (wp - rp) == FULL_LVL;
    assign FIFO_EMPTY = (wp == rp);
    assign wr         = (state != IDLE) && !full;
    assign rd         = FIFO_READ && !FIFO_EMPTY;
    assign FIFO_DATA  = mem[rp[AW-1:0]];

    always_ff @(posedge BUS_CLK) begin
        if (wr) mem[wp[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + (AW + 1)'(1);
            if (rd) rp <= rp + (AW + 1)'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (BUS_ADD)
            ABUSWIDTH'(0): rd_mux = 8'd3;
            ABUSWIDTH'(1): rd_mux = {5'b0, conf_ext_en, conf_ext_ts, conf_en};
            ABUSWIDTH'(2): rd_mux = rise16[7:0];
            ABUSWIDTH'(3): rd_mux = rise16[15:8];
            ABUSWIDTH'(4): rd_mux = fall16[7:0];
            ABUSWIDTH'(5): rd_mux = fall16[15:8];
            ABUSWIDTH'(6): rd_mux = lost_cnt;
            ABUSWIDTH'(7): rd_mux = 8'(pend_cnt);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst)         BUS_DATA_OUT <= '0;
        else if (BUS_RD) BUS_DATA_OUT <= rd_mux;
    end

endmodule

// File: tb/tb_multi_timestamp_core.sv
// Bench for multi_timestamp_core: expected-word queue built from the event
// rules, checked on every FIFO pop; counter model checked every cycle.
module tb_multi_timestamp_core;

    localparam int CH    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          BUS_RST = 1'b1;
    logic [CH-1:0] DI = '0;
    logic          EXT_ENABLE = 1'b0;
    logic [63:0]   EXT_TIMESTAMP = '0;
    logic [63:0]   TIMESTAMP_OUT;
    logic          FIFO_READ = 1'b0;
    logic          FIFO_EMPTY;
    logic [31:0]   FIFO_DATA;
    logic [15:0]   BUS_ADD = '0;
    logic [7:0]    BUS_DATA_IN = '0;
    logic [7:0]    BUS_DATA_OUT;
    logic          BUS_WR = 1'b0;
    logic          BUS_RD = 1'b0;

    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;
    logic [63:0] m_cnt = '0;
    int          m_last = CH - 1;
    logic [31:0] exp_q [$];

    multi_timestamp_core #(
        .ABUSWIDTH(16), .IDENTIFIER(4'b0001), .CHANNELS(CH),
        .TS_WIDTH(64), .DEPTH(DEPTH)
    ) dut (
        .BUS_CLK(clk), .BUS_RST(BUS_RST), .DI(DI),
        .EXT_ENABLE(EXT_ENABLE), .EXT_TIMESTAMP(EXT_TIMESTAMP),
        .TIMESTAMP_OUT(TIMESTAMP_OUT), .FIFO_READ(FIFO_READ),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD)
    );

    always #5 clk = ~clk;

    // Time base: cycles since the last reset edge
    always @(posedge clk) begin
        if (BUS_RST || (BUS_WR && BUS_ADD == 16'd0)) m_cnt <= '0;
        else m_cnt <= m_cnt + 64'd1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("timestamp", TIMESTAMP_OUT, m_cnt);
            if (FIFO_READ && !FIFO_EMPTY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_extra: got %h required no word", FIFO_DATA);
                end else begin
                    chk("fifo_word", FIFO_DATA, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk) #1;
    endtask

    task automatic push_event(input logic [63:0] ts, input int ch, input bit rising);
        exp_q.push_back({8'h11, ts[23:0]});
        exp_q.push_back({8'h12, ts[47:24]});
        exp_q.push_back({8'h13, 4'(ch), rising, 3'b000, ts[63:48]});
        m_last = ch;
    endtask

    task automatic push_burst(input logic [63:0] ts, input logic [CH-1:0] m, input bit rising);
        int start;
        start = m_last;
        for (int k = 1; k <= CH; k++) begin
            int c;
            c = (start + k) % CH;
            if (m[c]) push_event(ts, c, rising);
        end
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        BUS_ADD = a;
        BUS_DATA_IN = d;
        BUS_WR = 1'b1;
        tick(1);
        BUS_WR = 1'b0;
        if (a == 16'd0) begin
            exp_q.delete();
            m_last = CH - 1;
        end
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        BUS_ADD = a;
        BUS_RD = 1'b1;
        tick(1);
        BUS_RD = 1'b0;
        chk(name, BUS_DATA_OUT, exp);
    endtask

    task automatic drain(input string name);
        FIFO_READ = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d words left required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(6);
        chk(name, FIFO_EMPTY, 1'b1);
        FIFO_READ = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ts;
        tick(2);
        BUS_RST = 1'b0;
        started = 1'b1;

        chk("rst_empty", FIFO_EMPTY, 1'b1);
        chk("rst_dout", BUS_DATA_OUT, 8'h00);
        rd_chk("rst_version", 16'd0, 8'h03);
        rd_chk("rst_conf", 16'd1, 8'h04);
        rd_chk("rst_rise_lo", 16'd2, 8'h0F);
        rd_chk("rst_rise_hi", 16'd3, 8'h00);
        rd_chk("rst_fall_lo", 16'd4, 8'h00);
        rd_chk("rst_lost", 16'd6, 8'h00);
        rd_chk("rst_pend", 16'd7, 8'h00);
        rd_chk("unused_addr", 16'd9, 8'h00);

        // Disabled: no capture with CONF_EN=0 and EXT_ENABLE=0
        DI[0] = 1'b1;
        tick(10);
        chk("dis_empty", FIFO_EMPTY, 1'b1);
        rd_chk("dis_pend", 16'd7, 8'h00);
        DI[0] = 1'b0;
        tick(4);

        // Test 1: single rise on CH0 sampled at counter 100
        wr_reg(16'd0, 8'h00);
        wr_reg(16'd1, 8'h01);
        for (int i = 0; i < 200 && m_cnt != 64'd99; i++) tick(1);
        DI[0] = 1'b1;
        exp_q.push_back(32'h1100_0065);
        exp_q.push_back(32'h1200_0000);
        exp_q.push_back(32'h1308_0000);
        m_last = 0;
        tick(4);
        DI[0] = 1'b0;
        drain("t1_empty");
        rd_chk("t1_lost", 16'd6, 8'h00);

        // Test 2: falling edge on CH1 only
        wr_reg(16'd2, 8'h00);
        wr_reg(16'd4, 8'h02);
        rd_chk("t2_rise", 16'd2, 8'h00);
        rd_chk("t2_fall", 16'd4, 8'h02);
        DI[1] = 1'b1;
        tick(8);
        DI[1] = 1'b0;
        ts = m_cnt + 64'd2;
        exp_q.push_back({8'h11, ts[23:0]});
        exp_q.push_back({8'h12, ts[47:24]});
        exp_q.push_back(32'h1310_0000);
        m_last = 1;
        tick(2);
        drain("t2_empty");

        // Test 3: two simultaneous bursts, both served from CH0
        wr_reg(16'd0, 8'h00);
        wr_reg(16'd1, 8'h01);
        DI = 4'hF;
        push_burst(m_cnt + 64'd2, 4'hF, 1'b1);
        tick(30);
        DI = 4'h0;
        tick(5);
        DI = 4'hF;
        push_burst(m_cnt + 64'd2, 4'hF, 1'b1);
        tick(30);
        DI = 4'h0;
        drain("t3_empty");
        rd_chk("t3_lost", 16'd6, 8'h00);

        // Test 4: FIFO held full, CH2 keeps toggling
        wr_reg(16'd0, 8'h00);
        wr_reg(16'd1, 8'h01);
        for (int k = 0; k < 5; k++) begin
            DI[0] = 1'b1;
            push_event(m_cnt + 64'd2, 0, 1'b1);
            tick(2);
            DI[0] = 1'b0;
            tick(6);
        end
        DI[2] = 1'b1;
        push_event(m_cnt + 64'd2, 2, 1'b1);
        tick(8);
        chk("t4_nonempty", FIFO_EMPTY, 1'b0);
        for (int k = 0; k < 300; k++) begin
            DI[2] = 1'b0;
            tick(1);
            DI[2] = 1'b1;
            tick(1);
        end
        tick(4);
        rd_chk("t4_lost_sat", 16'd6, 8'd255);
        rd_chk("t4_pend", 16'd7, 8'h01);
        DI[2] = 1'b0;
        tick(4);
        rd_chk("t4_lost_hold", 16'd6, 8'd255);
        drain("t4_empty");
        rd_chk("t4_pend_clr", 16'd7, 8'h00);

        // Test 5: external time base, capture via EXT_ENABLE
        wr_reg(16'd0, 8'h00);
        EXT_TIMESTAMP = 64'h0123_4567_89AB_CDEF;
        EXT_ENABLE = 1'b1;
        wr_reg(16'd1, 8'h06);
        DI[2] = 1'b1;
        exp_q.push_back(32'h11AB_CDEF);
        exp_q.push_back(32'h1245_6789);
        exp_q.push_back(32'h1328_0123);
        m_last = 2;
        tick(6);
        DI[2] = 1'b0;
        drain("t5_empty");
        EXT_ENABLE = 1'b0;

        // Test 6: soft reset while the serialiser is in W2
        wr_reg(16'd1, 8'h01);
        DI[3] = 1'b1;
        push_event(m_cnt + 64'd2, 3, 1'b1);
        tick(5);
        chk("t6_w1_written", FIFO_EMPTY, 1'b0);
        wr_reg(16'd0, 8'h00);
        chk("t6_empty", FIFO_EMPTY, 1'b1);
        chk("t6_cnt", TIMESTAMP_OUT, 64'd0);
        rd_chk("t6_conf", 16'd1, 8'h04);
        rd_chk("t6_version", 16'd0, 8'h03);
        DI[3] = 1'b0;
        tick(10);
        chk("t6_still_empty", FIFO_EMPTY, 1'b1);
        rd_chk("t6_pend", 16'd7, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
